pe_feeder: RTL
==============

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 3, which is the PE word-address width.
REQ-002 The block SHALL have the parameter POLL_MAX, default 255, which is the maximum number of not-done status polls before timeout.
REQ-003 The block SHALL have port clk, input, width 1, the single clock, rising edge.
REQ-004 The block SHALL have port reset_n, input, width 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 32) and in_b (input, 32), forming the operand-pair stream.
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32), forming the result stream.
REQ-007 The block SHALL have ports req_o (output, 1), wen_o (output, 4), addr_o (output, ADDR_W), wdata_o (output, 32) and rdata_i (input, 32), forming the SRAM-like master port to the PE.
REQ-008 The block SHALL have port busy_o (output, 1), high in every state except IDLE.
REQ-009 The block SHALL have port err_o (output, 1), a sticky timeout flag.

Function
REQ-010 The PE word map SHALL be: 0 = OP_A, 1 = OP_B, 2 = CTRL (bit0 = start), 3 = STATUS (bit0 = done), 4 = RESULT.
REQ-011 The FSM states SHALL be IDLE, WR_A, WR_B, START, POLL_REQ, POLL_CHK, RD_REQ, RD_CAP and OUT.
REQ-012 in_ready SHALL be 1 only in IDLE; the handshake in_valid&in_ready SHALL latch in_a and in_b and move the FSM to WR_A.
REQ-013 WR_A SHALL drive req_o=1, wen_o=4'hF, addr_o=0 and wdata_o=a; WR_B SHALL do the same with addr_o=1 and wdata_o=b; START SHALL do the same with addr_o=2 and wdata_o=32'h1; each state SHALL last exactly 1 cycle.
REQ-014 POLL_REQ SHALL drive req_o=1, wen_o=0 and addr_o=3; read data SHALL be valid on rdata_i in the following cycle (POLL_CHK).
REQ-015 In POLL_CHK, rdata_i[0]=1 SHALL move the FSM to RD_REQ; rdata_i[0]=0 SHALL increment the poll counter and return the FSM to POLL_REQ.
REQ-016 RD_REQ SHALL read addr 4; RD_CAP SHALL register rdata_i into out_data; OUT SHALL hold out_valid=1 with out_data stable until out_ready=1, then move the FSM to IDLE.
REQ-017 Minimum latency SHALL be: handshake in cycle T gives out_valid=1 in cycle T+8, when done is seen at the first poll.
REQ-018 In non-access states, req_o, wen_o, addr_o and wdata_o SHALL all be 0.
REQ-019 in_valid SHALL be ignored while the block is busy, with no queuing.
REQ-020 The poll counter SHALL be 8 bits, SHALL be cleared on each accepted input, and SHALL saturate at all-ones rather than wrap.
REQ-021 The out_ready value during IDLE..RD_CAP SHALL have no effect.

Reset
REQ-022 Asserting reset_n=0 SHALL immediately force IDLE, in_ready=1 after deassertion, out_valid=0, out_data=0, req_o=0, wen_o=0, addr_o=0, wdata_o=0, busy_o=0, err_o=0 and clear the poll counter.
REQ-023 Reset mid-operation SHALL abandon the transaction; no further PE access SHALL occur, and the PE is not informed.

Configuration
REQ-024 With PE_FEEDER_TIMEOUT_EN defined, a not-done POLL_CHK when the counter equals POLL_MAX SHALL set err_o=1 and emit out_data=32'hDEAD_BEEF via OUT.
REQ-025 err_o SHALL clear only on reset.
REQ-026 Without PE_FEEDER_TIMEOUT_EN, polling SHALL be unbounded and err_o SHALL be tied 0.

Structure
REQ-027 Package pe_pkg SHALL hold the word-address constants (OP_A..RESULT), the CTRL start bit, the STATUS done bit, the feeder state enum and the timeout pattern 32'hDEAD_BEEF.
REQ-028 The block SHALL be a single module with no sub-modules; the FSM, operand registers, poll counter and result register SHALL all be local.

Verification
REQ-029 Scenario: a=3, b=5, PE model raises done at the first poll with RESULT=15 -> writes (0,3), (1,5), (2,1), then read 3, read 4, out_valid at T+8 with out_data=15.
REQ-030 Scenario: done asserted after 4 polls -> exactly 4 addr-3 reads, then an addr-4 read, out_valid at T+14.
REQ-031 Scenario: out_ready held 0 for 10 cycles -> out_data stable, in_ready=0, no PE access, IDLE one cycle after out_ready=1.
REQ-032 Scenario: reset_n pulsed low during POLL_REQ -> all outputs 0 asynchronously, and a following transaction completes correctly.
REQ-033 Scenario (TIMEOUT_EN, POLL_MAX=3): done never rises -> 4 status reads, err_o=1, out_data=32'hDEAD_BEEF.
REQ-034 Scenario: back-to-back inputs with in_valid held high -> the second pair is accepted only in the cycle after the first out handshake.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants for the PE feeder: PE word map, control/status bits, FSM encoding and the
// timeout result pattern.
package pe_pkg;

   localparam int unsigned PE_ADDR_OP_A   = 0;
   localparam int unsigned PE_ADDR_OP_B   = 1;
   localparam int unsigned PE_ADDR_CTRL   = 2;
   localparam int unsigned PE_ADDR_STATUS = 3;
   localparam int unsigned PE_ADDR_RESULT = 4;

   localparam int unsigned PE_CTRL_START_BIT  = 0;
   localparam int unsigned PE_STATUS_DONE_BIT = 0;

   localparam logic [31:0] PE_TIMEOUT_PATTERN = 32'hDEAD_BEEF;

   // Feeder state encoding
   typedef logic [3:0] feeder_state_t;

   localparam feeder_state_t ST_IDLE     = 4'd0;
   localparam feeder_state_t ST_WR_A     = 4'd1;
   localparam feeder_state_t ST_WR_B     = 4'd2;
   localparam feeder_state_t ST_START    = 4'd3;
   localparam feeder_state_t ST_POLL_REQ = 4'd4;
   localparam feeder_state_t ST_POLL_CHK = 4'd5;
   localparam feeder_state_t ST_RD_REQ   = 4'd6;
   localparam feeder_state_t ST_RD_CAP   = 4'd7;
   localparam feeder_state_t ST_OUT      = 4'd8;

endpackage

// File: rtl/pe_feeder.sv
// Feeds operand pairs to a memory-mapped PE, polls its status and returns the result.
// Optional PE_FEEDER_TIMEOUT_EN bounds polling and reports a sticky timeout on err_o.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned POLL_MAX = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              req_o,
   output logic [3:0]        wen_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [31:0]       wdata_o,
   input  logic [31:0]       rdata_i,
   output logic              busy_o,
   output logic              err_o
);

   feeder_state_t state_q, state_d;
   logic [31:0]   op_a_q, op_b_q;
   logic [31:0]   out_data_q;
   logic [7:0]    poll_cnt_q;
   logic          status_done;
   logic          timeout_hit;
   logic          poll_miss;

   assign status_done = rdata_i[PE_STATUS_DONE_BIT];
   assign poll_miss   = (state_q == ST_POLL_CHK) && !status_done;

`ifdef PE_FEEDER_TIMEOUT_EN
   logic err_q;

   assign timeout_hit = (32'(poll_cnt_q) == POLL_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (poll_miss && timeout_hit) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_o       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (in_valid) state_d = ST_WR_A;
         ST_WR_A:     state_d = ST_WR_B;
         ST_WR_B:     state_d = ST_START;
         ST_START:    state_d = ST_POLL_REQ;
         ST_POLL_REQ: state_d = ST_POLL_CHK;
         ST_POLL_CHK: begin
            if (status_done) begin
               state_d = ST_RD_REQ;
            end else if (timeout_hit) begin
               state_d = ST_OUT;
            end else begin
               state_d = ST_POLL_REQ;
            end
         end
         ST_RD_REQ:   state_d = ST_RD_CAP;
         ST_RD_CAP:   state_d = ST_OUT;
         ST_OUT:      if (out_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         op_a_q     <= 32'h0;
         op_b_q     <= 32'h0;
         poll_cnt_q <= 8'h0;
         out_data_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && in_valid) begin
            op_a_q     <= in_a;
            op_b_q     <= in_b;
            poll_cnt_q <= 8'h0;
         end
         // Counter saturates so a long-running PE never aliases back to a small count
         if (poll_miss && (poll_cnt_q != 8'hFF)) begin
            poll_cnt_q <= poll_cnt_q + 8'd1;
         end
         if (state_q == ST_RD_CAP) begin
            out_data_q <= rdata_i;
         end else if (poll_miss && timeout_hit) begin
            out_data_q <= PE_TIMEOUT_PATTERN;
         end
      end
   end

   always_comb begin
      req_o   = 1'b0;
      wen_o   = 4'h0;
      addr_o  = '0;
      wdata_o = 32'h0;
      case (state_q)
         ST_WR_A: begin
            req_o   = 1'b1;
            wen_o   = 4'hF;
            addr_o  = ADDR_W'(PE_ADDR_OP_A);
            wdata_o = op_a_q;
         end
         ST_WR_B: begin
            req_o   = 1'b1;
            wen_o   = 4'hF;
            addr_o  = ADDR_W'(PE_ADDR_OP_B);
            wdata_o = op_b_q;
         end
         ST_START: begin
            req_o   = 1'b1;
            wen_o   = 4'hF;
            addr_o  = ADDR_W'(PE_ADDR_CTRL);
            wdata_o = 32'h1 << PE_CTRL_START_BIT;
         end
         ST_POLL_REQ: begin
            req_o  = 1'b1;
            addr_o = ADDR_W'(PE_ADDR_STATUS);
         end
         ST_RD_REQ: begin
            req_o  = 1'b1;
            addr_o = ADDR_W'(PE_ADDR_RESULT);
         end
         default: ;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy_o    = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_OUT);
   assign out_data  = out_data_q;

endmodule
